// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
package mult_pkg;

  // Controller states; completion is a registered pulse, not a state.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Booth recoding of {q0, q(-1)}.
  typedef enum logic [1:0] {
    NOP = 2'b00,
    ADD = 2'b01,
    SUB = 2'b10
  } booth_op_t;

  // Counter width able to hold the values 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/booth_radix2_step.sv
// One radix-2 Booth iteration: conditional add/sub into the upper half of
// {acc, q, q(-1)} followed by an arithmetic right shift of the whole vector.
module booth_radix2_step
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [2*N+3:0] vec_in,
  input  logic [N:0]     mcand,
  output logic [2*N+3:0] vec_out
);

  booth_op_t    op_s;
  logic [N+1:0] acc_s;
  logic [N+1:0] mext_s;
  logic [N+1:0] sum_s;

  assign acc_s  = vec_in[2*N+3:N+2];
  assign mext_s = {mcand[N], mcand};

  // Recode the two low bits {q0, q(-1)} into an adder operation.
  always_comb begin
    op_s = NOP;
    case (vec_in[1:0])
      2'b01:   op_s = ADD;
      2'b10:   op_s = SUB;
      default: op_s = NOP;
    endcase
  end

  // Apply the operation to the accumulator; N+2 bits keeps -(-2^N) in range.
  always_comb begin
    sum_s = acc_s;
    case (op_s)
      ADD:     sum_s = acc_s + mext_s;
      SUB:     sum_s = acc_s - mext_s;
      default: sum_s = acc_s;
    endcase
  end

  // Arithmetic shift right: replicate the accumulator sign, drop old q(-1).
  always_comb begin
    vec_out = {sum_s[N+1], sum_s, vec_in[N+1:1]};
  end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier: N+1 add/shift steps with a single
// adder, per-operand signedness, start/busy/done handshake.
module seq_booth_multiplier
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           a_signed,
  input  logic           b_signed,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = cnt_width(N);

  state_t           state_r;
  state_t           state_s;
  logic             busy_r;
  logic             done_r;
  logic [2*N-1:0]   product_r;
  logic [2*N+3:0]   vec_r;
  logic [2*N+3:0]   step_s;
  logic [N:0]       mcand_r;
  logic [CW-1:0]    cnt_r;
  logic             last_s;
  logic [N:0]       a_ext_s;
  logic [N:0]       b_ext_s;

  assign a_ext_s = {a_signed & a[N-1], a};
  assign b_ext_s = {b_signed & b[N-1], b};
  assign last_s  = (cnt_r == CW'(N));

  booth_radix2_step #(.N(N)) u_step (
    .vec_in  (vec_r),
    .mcand   (mcand_r),
    .vec_out (step_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: accept start only when idle, finish after step N+1.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_s = IDLE;
        end else begin
          state_s = BUSY;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand capture, Booth iteration, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= '0;
      vec_r     <= '0;
      mcand_r   <= '0;
      cnt_r     <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            mcand_r <= a_ext_s;
            vec_r   <= {{(N+2){1'b0}}, b_ext_s, 1'b0};
            cnt_r   <= '0;
            busy_r  <= 1'b1;
          end
        end
        BUSY: begin
          vec_r <= step_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            // Low 2N bits of {acc, q}; q(-1) at bit 0 is skipped.
            product_r <= step_s[2*N:1];
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule
